cp0_exc_ctrl: RTL and testbench
===============================

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h8000_0180, general exception handler address.
REQ-002 SHALL have parameter REFILL_VECTOR, default 32'h8000_0000, TLB-refill handler address.
REQ-003 SHALL have ports: clk in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: exc_req in 1, pipeline exception request; exc_code in 5, ExcCode; exc_refill in 1, TLB refill miss; exc_bd in 1, faulting instr in delay slot.
REQ-005 SHALL have ports: exc_pc in 32, faulting instr PC; exc_badvaddr in 32, faulting address.
REQ-006 SHALL have ports: eret_req in 1, ERET at commit; hw_int in 6, level-sensitive interrupt lines.
REQ-007 SHALL have ports: cp0_status, cp0_cause, cp0_epc in 32 each, current CP0 register values.
REQ-008 SHALL have ports: in_epc, in_status, in_cause, in_badVAddr out 32 each, write data; we_epc, we_status, we_cause, we_badVAddr out 1 each, write strobes.
REQ-009 SHALL have ports: busy out 1, stall pipeline; flush out 1, squash pipeline; redirect out 1, PC load strobe; redirect_pc out 32, new PC.

Function
REQ-010 FSM states SHALL be IDLE, SAVE, REDIRECT, ERET_WB.
REQ-011 Status fields: bit0 IE, bit1 EXL; Cause fields: [6:2] ExcCode, [15:10] IP, bit31 BD.
REQ-012 In IDLE, int_take = |(hw_int & cp0_status[15:10]) & IE & !EXL.
REQ-013 IDLE priority SHALL be exc_req > int_take > eret_req; only one event accepted per cycle; lower ones ignored that cycle.
REQ-014 On acceptance SHALL latch code (interrupt code = 5'd0), pc, badvaddr, bd, refill into internal registers; busy asserts from next cycle until return to IDLE.
REQ-015 exc_req or int_take in IDLE -> SAVE; eret_req -> ERET_WB.
REQ-016 SAVE (one cycle): SHALL pulse we_epc (in_epc = bd ? pc-4 : pc) only if cp0_status.EXL==0; we_cause (in_cause = cp0_cause with ExcCode, BD, IP=hw_int replaced); we_status (in_status = cp0_status | 32'h2).
REQ-017 SAVE SHALL pulse we_badVAddr with latched badvaddr only for codes 4, 5, 2, 3 (AdEL, AdES, TLBL, TLBS).
REQ-018 SAVE -> REDIRECT unconditionally.
REQ-019 REDIRECT (one cycle): flush=1, redirect=1; redirect_pc = REFILL_VECTOR if refill && EXL was 0 at acceptance, else EXC_VECTOR; -> IDLE.
REQ-020 ERET_WB (one cycle): we_status with in_status = cp0_status & ~32'h2; flush=1, redirect=1, redirect_pc = cp0_epc; -> IDLE.
REQ-021 All we_*, flush, redirect SHALL be registered-state decoded, high exactly one cycle per event; in_* don't-care when strobe low but driven to 0.
REQ-022 Event arriving while busy SHALL be ignored; pipeline holds it under busy.
REQ-023 Exception-to-redirect latency: accept at cycle N, strobes at N+1, redirect at N+2; ERET redirect at N+1.

Reset
REQ-024 rst_n low SHALL force IDLE, latched regs 0, all outputs 0, asynchronously; mid-sequence reset abandons event with no further strobes.
REQ-025 First event accepted on first clk edge after rst_n deasserts.

Structure
REQ-026 ExcCode constants, Status/Cause bit positions and FSM state encoding SHALL live in shared header cp0.vh beside mmu.vh.
REQ-027 Single module; no sub-modules.

Verification
REQ-028 exc_req code 5'd4, pc 32'h400, badvaddr 32'h1001, EXL=0 -> cycle+1 we_epc 32'h400, we_badVAddr 32'h1001, in_status EXL set; cycle+2 redirect_pc 32'h8000_0180.
REQ-029 exc_req code 2, refill=1, bd=1, pc 32'h408, EXL=0 -> in_epc 32'h404, Cause bit31=1, redirect_pc 32'h8000_0000.
REQ-030 Status 32'h0000_0401, hw_int=6'b000001 -> SAVE with ExcCode 0, IP=1; same with IE=0 -> no action.
REQ-031 eret_req, cp0_epc 32'h1234, status 32'h3 -> next cycle in_status 32'h1, redirect_pc 32'h1234.
REQ-032 exc_req and eret_req same cycle -> exception taken; with EXL=1 -> no we_epc, redirect EXC_VECTOR.
REQ-033 rst_n low during SAVE -> all strobes 0 immediately, IDLE after release.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// rtl/cp0_exc_ctrl_pkg.sv - CP0 exception controller shared constants, states and field helpers
package cp0_exc_ctrl_pkg;

    // ExcCode values the controller has to distinguish
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Status / Cause bit positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 10;
    localparam int STATUS_IM_HI  = 15;
    localparam int CAUSE_CODE_LO = 2;
    localparam int CAUSE_CODE_HI = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_EXL_MASK = 32'h0000_0002;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAVE     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_ERET_WB  = 2'd3
    } state_e;

    // Address-error and TLB-miss codes are the only ones that report a faulting address
    function automatic logic needs_badvaddr(input logic [4:0] code);
        return (code == EXC_TLBL) || (code == EXC_TLBS) ||
               (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

    // Keep every Cause bit the controller does not own, replace ExcCode, IP and BD
    function automatic logic [31:0] cause_merge(input logic [31:0] cause,
                                                input logic [4:0]  code,
                                                input logic [5:0]  ip,
                                                input logic        bd);
        logic [31:0] r;
        r = cause;
        r[CAUSE_CODE_HI:CAUSE_CODE_LO] = code;
        r[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
        r[CAUSE_BD]                    = bd;
        return r;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/interrupt/ERET sequencer driving CP0 write strobes and PC redirect
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h8000_0180,
    parameter logic [31:0] REFILL_VECTOR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        exc_refill,
    input  logic        exc_bd,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_req,
    input  logic [5:0]  hw_int,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic [31:0] in_epc,
    output logic [31:0] in_status,
    output logic [31:0] in_cause,
    output logic [31:0] in_badVAddr,
    output logic        we_epc,
    output logic        we_status,
    output logic        we_cause,
    output logic        we_badVAddr,
    output logic        busy,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    state_e      state_q;
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic [31:0] badvaddr_q;
    logic        bd_q;
    logic        refill_q;
    logic        exl_q;
    logic [5:0]  ip_q;

    logic        int_take;
    logic        take_exc;

    // Interrupt is taken only when an enabled line is pending and we are not already in a handler
    always_comb begin
        int_take = (|(hw_int & cp0_status[STATUS_IM_HI:STATUS_IM_LO])) &
                   cp0_status[STATUS_IE] & ~cp0_status[STATUS_EXL];
        take_exc = exc_req | int_take;
    end

    // Sequencer: accept one event in IDLE, capture its context, then walk the fixed write/redirect steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            pc_q       <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            refill_q   <= 1'b0;
            exl_q      <= 1'b0;
            ip_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_exc) begin
                        state_q    <= ST_SAVE;
                        code_q     <= exc_req ? exc_code : EXC_INT;
                        pc_q       <= exc_pc;
                        badvaddr_q <= exc_badvaddr;
                        bd_q       <= exc_bd;
                        refill_q   <= exc_req & exc_refill;
                        exl_q      <= cp0_status[STATUS_EXL];
                        ip_q       <= hw_int;
                    end else if (eret_req) begin
                        state_q <= ST_ERET_WB;
                    end
                end
                ST_SAVE:     state_q <= ST_REDIRECT;
                ST_REDIRECT: state_q <= ST_IDLE;
                ST_ERET_WB:  state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs are a pure decode of the registered state, so each strobe lasts exactly one state cycle
    always_comb begin
        in_epc      = '0;
        in_status   = '0;
        in_cause    = '0;
        in_badVAddr = '0;
        we_epc      = 1'b0;
        we_status   = 1'b0;
        we_cause    = 1'b0;
        we_badVAddr = 1'b0;
        busy        = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (state_q)
            ST_SAVE: begin
                busy = 1'b1;
                // A nested exception must not clobber the EPC of the handler already running
                if (!cp0_status[STATUS_EXL]) begin
                    we_epc = 1'b1;
                    in_epc = bd_q ? (pc_q - 32'd4) : pc_q;
                end
                we_status = 1'b1;
                in_status = cp0_status | STATUS_EXL_MASK;
                we_cause  = 1'b1;
                in_cause  = cause_merge(cp0_cause, code_q, ip_q, bd_q);
                if (needs_badvaddr(code_q)) begin
                    we_badVAddr = 1'b1;
                    in_badVAddr = badvaddr_q;
                end
            end
            ST_REDIRECT: begin
                busy     = 1'b1;
                flush    = 1'b1;
                redirect = 1'b1;
                // Refill misses taken from inside a handler go through the general vector
                redirect_pc = (refill_q && !exl_q) ? REFILL_VECTOR : EXC_VECTOR;
            end
            ST_ERET_WB: begin
                busy        = 1'b1;
                we_status   = 1'b1;
                in_status   = cp0_status & ~STATUS_EXL_MASK;
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = cp0_epc;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - self-checking bench for cp0_exc_ctrl: directed vectors, reset corners, random vs model
module tb_cp0_exc_ctrl;

    localparam logic [31:0] EXC_V    = 32'h8000_0180;
    localparam logic [31:0] REFILL_V = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        exc_refill;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic [31:0] exc_badvaddr;
    logic        eret_req;
    logic [5:0]  hw_int;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] in_epc, in_status, in_cause, in_badVAddr;
    logic        we_epc, we_status, we_cause, we_badVAddr;
    logic        busy, flush, redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .exc_req(exc_req), .exc_code(exc_code), .exc_refill(exc_refill), .exc_bd(exc_bd),
        .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr), .eret_req(eret_req), .hw_int(hw_int),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .in_epc(in_epc), .in_status(in_status), .in_cause(in_cause), .in_badVAddr(in_badVAddr),
        .we_epc(we_epc), .we_status(we_status), .we_cause(we_cause), .we_badVAddr(we_badVAddr),
        .busy(busy), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    typedef struct packed {
        logic        busy;
        logic        flush;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        we_epc;
        logic [31:0] in_epc;
        logic        we_status;
        logic [31:0] in_status;
        logic        we_cause;
        logic [31:0] in_cause;
        logic        we_bad;
        logic [31:0] in_bad;
    } out_t;

    typedef struct {
        string       name;
        logic        exc_req;
        logic [4:0]  code;
        logic        refill;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        eret;
        logic [5:0]  hw_int;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        out_t        exp1;
        out_t        exp2;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];
    out_t exp_q[$];

    function automatic out_t act();
        out_t r;
        r.busy = busy; r.flush = flush; r.redirect = redirect; r.redirect_pc = redirect_pc;
        r.we_epc = we_epc; r.in_epc = in_epc; r.we_status = we_status; r.in_status = in_status;
        r.we_cause = we_cause; r.in_cause = in_cause; r.we_bad = we_badVAddr; r.in_bad = in_badVAddr;
        return r;
    endfunction

    function automatic out_t mk_save(bit wepc, logic [31:0] epc, logic [31:0] st,
                                     logic [31:0] ca, bit wbad, logic [31:0] bad);
        out_t r = '0;
        r.busy = 1'b1;
        r.we_epc = wepc;     r.in_epc = wepc ? epc : 32'h0;
        r.we_status = 1'b1;  r.in_status = st;
        r.we_cause = 1'b1;   r.in_cause = ca;
        r.we_bad = wbad;     r.in_bad = wbad ? bad : 32'h0;
        return r;
    endfunction

    function automatic out_t mk_redir(logic [31:0] pc);
        out_t r = '0;
        r.busy = 1'b1; r.flush = 1'b1; r.redirect = 1'b1; r.redirect_pc = pc;
        return r;
    endfunction

    function automatic out_t mk_eret(logic [31:0] st, logic [31:0] pc);
        out_t r = '0;
        r.busy = 1'b1; r.we_status = 1'b1; r.in_status = st;
        r.flush = 1'b1; r.redirect = 1'b1; r.redirect_pc = pc;
        return r;
    endfunction

    function automatic vec_t mk_vec(string n, logic er, logic [4:0] c, logic rf, logic bd,
                                    logic [31:0] pc, logic [31:0] bad, logic ert, logic [5:0] hi,
                                    logic [31:0] st, logic [31:0] ca, logic [31:0] ep,
                                    out_t e1, out_t e2);
        vec_t v;
        v.name = n; v.exc_req = er; v.code = c; v.refill = rf; v.bd = bd; v.pc = pc; v.bad = bad;
        v.eret = ert; v.hw_int = hi; v.status = st; v.cause = ca; v.epc = ep; v.exp1 = e1; v.exp2 = e2;
        return v;
    endfunction

    task automatic check(string name, out_t a, out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    task automatic clear_events();
        exc_req = 1'b0; eret_req = 1'b0; hw_int = 6'd0;
        exc_code = 5'd0; exc_refill = 1'b0; exc_bd = 1'b0; exc_pc = 32'h0; exc_badvaddr = 32'h0;
    endtask

    // Reference behaviour: decide what one accepted event should produce over the following cycles
    task automatic model_accept();
        bit          intr;
        logic [4:0]  code;
        logic [31:0] epc, cause;
        bit          refill, badok, exl;
        exl  = cp0_status[1];
        intr = ((hw_int & cp0_status[15:10]) != 6'd0) && cp0_status[0] && !exl;
        if (exc_req || intr) begin
            code   = exc_req ? exc_code : 5'd0;
            refill = exc_req && exc_refill;
            epc    = exc_bd ? exc_pc - 32'd4 : exc_pc;
            cause  = (cp0_cause & ~32'h8000_FC7C) | (exc_bd ? 32'h8000_0000 : 32'h0)
                     | (32'(hw_int) << 10) | (32'(code) << 2);
            badok  = exc_req && (code >= 5'd2) && (code <= 5'd5);
            exp_q.push_back(mk_save(!exl, epc, cp0_status | 32'h2, cause, badok, exc_badvaddr));
            exp_q.push_back(mk_redir((refill && !exl) ? REFILL_V : EXC_V));
        end else if (eret_req) begin
            exp_q.push_back(mk_eret(cp0_status & ~32'h2, cp0_epc));
        end
    endtask

    initial begin
        out_t e;
        rst_n = 1'b0;
        clear_events();
        cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;

        vecs.push_back(mk_vec("adel_basic", 1, 5'd4, 0, 0, 32'h400, 32'h1001, 0, 6'd0, 32'h0, 32'h0, 32'h0,
                              mk_save(1, 32'h400, 32'h2, 32'h10, 1, 32'h1001), mk_redir(EXC_V)));
        vecs.push_back(mk_vec("tlbl_refill_bd", 1, 5'd2, 1, 1, 32'h408, 32'h2000, 0, 6'd0, 32'h0, 32'h0, 32'h0,
                              mk_save(1, 32'h404, 32'h2, 32'h8000_0008, 1, 32'h2000), mk_redir(REFILL_V)));
        vecs.push_back(mk_vec("int_taken", 0, 5'd0, 0, 0, 32'h500, 32'h0, 0, 6'b000001, 32'h401, 32'h0, 32'h0,
                              mk_save(1, 32'h500, 32'h403, 32'h400, 0, 32'h0), mk_redir(EXC_V)));
        vecs.push_back(mk_vec("int_ie0", 0, 5'd0, 0, 0, 32'h500, 32'h0, 0, 6'b000001, 32'h400, 32'h0, 32'h0,
                              '0, '0));
        vecs.push_back(mk_vec("eret", 0, 5'd0, 0, 0, 32'h0, 32'h0, 1, 6'd0, 32'h3, 32'h0, 32'h1234,
                              mk_eret(32'h1, 32'h1234), '0));
        vecs.push_back(mk_vec("exc_over_eret", 1, 5'd12, 0, 0, 32'h600, 32'h0, 1, 6'd0, 32'h0, 32'h0, 32'h9999,
                              mk_save(1, 32'h600, 32'h2, 32'h30, 0, 32'h0), mk_redir(EXC_V)));
        vecs.push_back(mk_vec("refill_exl1", 1, 5'd3, 1, 0, 32'h680, 32'h3000, 1, 6'd0, 32'h2, 32'h0, 32'h0,
                              mk_save(0, 32'h0, 32'h2, 32'h0C, 1, 32'h3000), mk_redir(EXC_V)));
        vecs.push_back(mk_vec("cause_keep", 1, 5'd5, 0, 0, 32'h700, 32'h44, 0, 6'b101010, 32'h0, 32'hFFFF_FFFF, 32'h0,
                              mk_save(1, 32'h700, 32'h2, 32'h7FFF_AB97, 1, 32'h44), mk_redir(EXC_V)));

        // Reset state with an event already pending; it must be taken on the first edge after release
        exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h800; exc_badvaddr = 32'h900;
        @(negedge clk); @(negedge clk);
        check("reset_state", act(), '0);
        rst_n = 1'b1;
        @(posedge clk); #1 clear_events();
        @(negedge clk); check("first_edge_save", act(), mk_save(1, 32'h800, 32'h2, 32'h10, 1, 32'h900));
        @(negedge clk); check("first_edge_redir", act(), mk_redir(EXC_V));
        @(negedge clk); check("first_edge_idle", act(), '0);

        foreach (vecs[i]) begin
            exc_req = vecs[i].exc_req; exc_code = vecs[i].code; exc_refill = vecs[i].refill;
            exc_bd = vecs[i].bd; exc_pc = vecs[i].pc; exc_badvaddr = vecs[i].bad;
            eret_req = vecs[i].eret; hw_int = vecs[i].hw_int;
            cp0_status = vecs[i].status; cp0_cause = vecs[i].cause; cp0_epc = vecs[i].epc;
            @(posedge clk); #1 clear_events();
            @(negedge clk); check({vecs[i].name, "_c1"}, act(), vecs[i].exp1);
            @(negedge clk); check({vecs[i].name, "_c2"}, act(), vecs[i].exp2);
            @(negedge clk); check({vecs[i].name, "_idle"}, act(), '0);
        end

        // Events presented while busy are dropped
        cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
        exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'hA00; exc_badvaddr = 32'hB00;
        @(posedge clk); #1 exc_code = 5'd5; exc_pc = 32'hC00; eret_req = 1'b1;
        @(negedge clk); check("busy_save", act(), mk_save(1, 32'hA00, 32'h2, 32'h10, 1, 32'hB00));
        @(negedge clk); check("busy_redir", act(), mk_redir(EXC_V));
        clear_events();
        @(negedge clk); check("busy_idle", act(), '0);

        // Reset mid-SAVE kills strobes immediately and the event is never resumed
        exc_req = 1'b1; exc_code = 5'd2; exc_refill = 1'b1; exc_pc = 32'hD00; exc_badvaddr = 32'hE00;
        @(posedge clk); #1 clear_events();
        @(negedge clk); check("mid_rst_save", act(), mk_save(1, 32'hD00, 32'h2, 32'h08, 1, 32'hE00));
        #2 rst_n = 1'b0;
        #1 check("mid_rst_async", act(), '0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); check("mid_rst_after1", act(), '0);
        @(negedge clk); check("mid_rst_after2", act(), '0);

        // Randomized traffic against the reference model
        exp_q.delete();
        for (int i = 0; i < 800; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : out_t'('0);
            check($sformatf("rand_%0d", i), act(), e);
            if (!e.busy) begin
                cp0_status = $urandom;
                cp0_cause  = $urandom;
                cp0_epc    = $urandom;
            end
            exc_req      = ($urandom_range(0, 3) == 0);
            exc_code     = 5'($urandom);
            exc_refill   = 1'($urandom);
            exc_bd       = 1'($urandom);
            exc_pc       = $urandom;
            exc_badvaddr = $urandom;
            eret_req     = ($urandom_range(0, 2) == 0);
            hw_int       = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'd0;
            if (!e.busy) model_accept();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
